// File: rtl/block_serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// block_serial_subtractor_pkg
// Purpose : shared constants and FSM state encoding for the block-serial
//           subtractor and its slice sub-module.
// Contents: WIDTH_DEF / BLK_DEF default geometry, state_e encoding.
// -----------------------------------------------------------------------------
package block_serial_subtractor_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int BLK_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/block_serial_subtractor_sub_skip_block.sv
// -----------------------------------------------------------------------------
// sub_skip_block
// Purpose : combinational BLK-bit slice subtractor with borrow-skip.
//           d = a - b - bin (mod 2^BLK), computed as a + ~b + ~bin.
// Ports   : a, b  [BLK-1:0] in  - minuend / subtrahend slice
//           bin          in  - borrow from the less significant slice
//           d    [BLK-1:0] out - difference slice
//           bout         out - borrow to the more significant slice
// -----------------------------------------------------------------------------
module sub_skip_block
  import block_serial_subtractor_pkg::*;
#(
  parameter int BLK = BLK_DEF
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           bin,
  output logic [BLK-1:0] d,
  output logic           bout
);

  logic [BLK:0]   sum_s;
  logic [BLK-1:0] prop_s;
  logic           skip_s;

  // Ripple sum of the slice and the block-propagate term.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, ~b} + {{BLK{1'b0}}, ~bin};
    prop_s = a ^ ~b;
    skip_s = &prop_s;
  end

  // When every bit propagates (a == b) the incoming borrow passes straight
  // through, so the outgoing borrow does not wait on the ripple chain.
  always_comb begin
    d = sum_s[BLK-1:0];
    if (skip_s) begin
      bout = bin;
    end else begin
      bout = ~sum_s[BLK];
    end
  end

endmodule

// File: rtl/block_serial_subtractor.sv
// -----------------------------------------------------------------------------
// block_serial_subtractor
// Purpose : computes A - B over WIDTH/BLK cycles, one BLK-bit slice per
//           cycle, least significant slice first, using a single shared
//           sub_skip_block.
// Ports   : clk            in  - clock, rising edge
//           rst            in  - synchronous active-high reset
//           start          in  - begin a subtraction (sampled in IDLE only)
//           A, B [WIDTH]   in  - minuend / subtrahend (captured on accept)
//           busy           out - high in RUN and DONE
//           done           out - one-cycle pulse, result valid
//           D    [WIDTH]   out - A - B mod 2^WIDTH (held until next DONE)
//           Bout           out - unsigned borrow (A < B)
//           V              out - signed overflow
//           Z              out - D == 0
// -----------------------------------------------------------------------------
module block_serial_subtractor
  import block_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLK   = BLK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [IDXW-1:0]  idx_q,    idx_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             bout_q,   bout_d;
  logic             v_q,      v_d;
  logic             z_q,      z_d;

  int               base_s;
  logic [BLK-1:0]   slice_a_s;
  logic [BLK-1:0]   slice_b_s;
  logic [BLK-1:0]   slice_d_s;
  logic             slice_bout_s;
  logic             last_s;

  // Select the operand slice addressed by the block index.
  always_comb begin
    base_s    = int'(idx_q) * BLK;
    slice_a_s = a_q[base_s +: BLK];
    slice_b_s = b_q[base_s +: BLK];
    last_s    = (idx_q == IDXW'(NBLK - 1));
  end

  sub_skip_block #(
    .BLK (BLK)
  ) u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .bin  (borrow_q),
    .d    (slice_d_s),
    .bout (slice_bout_s)
  );

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    dout_d   = dout_q;
    bout_d   = bout_q;
    v_d      = v_q;
    z_d      = z_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          acc_d    = {WIDTH{1'b0}};
          idx_d    = {IDXW{1'b0}};
          borrow_d = 1'b0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d[base_s +: BLK] = slice_d_s;
        borrow_d             = slice_bout_s;
        if (last_s) begin
          // Index wraps to zero explicitly so non-power-of-two block counts
          // also leave the counter clean for the next operation.
          idx_d   = {IDXW{1'b0}};
          state_d = DONE;
          dout_d  = acc_d;
          bout_d  = slice_bout_s;
          v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          z_d     = (acc_d == {WIDTH{1'b0}});
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; the next operation is
        // accepted from IDLE on the following cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      idx_q    <= {IDXW{1'b0}};
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = dout_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_block_serial_subtractor
// Scoreboard bench: the driver pushes the arithmetic expectation (plus the
// time of the accepting edge) for every accepted start; a monitor on the
// falling edge pops and compares whenever done is high, and otherwise checks
// that the result outputs hold their last value.
// -----------------------------------------------------------------------------
module tb_block_serial_subtractor;

  localparam int W    = 32;
  localparam int BLK  = 4;
  localparam int NBLK = W / BLK;
  localparam int P    = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, Bout, V, Z;
  logic [W-1:0] D;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    logic         z;
    time          t_s;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;
  exp_t hold;

  block_serial_subtractor #(.WIDTH(W), .BLK(BLK)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V), .Z(Z)
  );

  always #(P/2) clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input time ts);
    exp_t   e;
    longint sa, sbv, sd;
    sa     = longint'($signed(a));
    sbv    = longint'($signed(b));
    sd     = sa - sbv;
    e.d    = a - b;
    e.bout = (a < b);
    e.v    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.z    = (e.d == 32'h0);
    e.t_s  = ts;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_hold_reset();
    hold.d = 32'h0; hold.bout = 1'b0; hold.v = 1'b0; hold.z = 1'b1; hold.t_s = 0;
  endtask

  // Monitor: compare on done, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("D", D, e.d);
          chk("Bout", {31'd0, Bout}, {31'd0, e.bout});
          chk("V", {31'd0, V}, {31'd0, e.v});
          chk("Z", {31'd0, Z}, {31'd0, e.z});
          // done cycle is NBLK edges after the accepting edge, i.e. the
          // (NBLK+1)th cycle counting the cycle start was sampled in.
          chk("latency", 32'(int'($time - e.t_s)), 32'(NBLK * P + P / 2));
          hold = e;
        end
      end else if (!rst) begin
        if (D !== hold.d || Bout !== hold.bout || V !== hold.v || Z !== hold.z) begin
          chk("hold_D", D, hold.d);
          chk("hold_flags", {29'd0, Bout, V, Z}, {29'd0, hold.bout, hold.v, hold.z});
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 4 * NBLK && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // One operation with junk operands and stray starts while busy; a start
  // in the done cycle must be ignored too.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(a, b, $time));
    for (int k = 1; k <= NBLK + 1; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_run", {31'd0, busy}, 32'd1);
      A = $urandom; B = $urandom;
      start = (k == NBLK + 1) ? 1'b1 : 1'($urandom % 2);
    end
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  // start held high: accepts every NBLK+2 cycles, operands only matter at
  // the accepting edges.
  task automatic back_to_back(input int n);
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      sb_q.push_back(model(a, b, $time));
      a = $urandom; b = $urandom;
      for (int k = 1; k <= NBLK + 2; k++) begin
        @(negedge clk);
        if (k == NBLK + 2) begin A = a; B = b; end
        else begin A = $urandom; B = $urandom; end
        if (j == n - 1 && k == NBLK + 2) start = 1'b0;
      end
    end
    drain();
  endtask

  // Abort at RUN cycle 4, then accept on the first IDLE cycle after reset.
  task automatic reset_abort();
    logic [W-1:0] a2, b2;
    a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    A = $urandom; B = $urandom; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      A = $urandom; B = $urandom; start = 1'b1;
    end
    rst = 1'b1; A = a2; B = b2;
    @(posedge clk);
    #1 set_hold_reset();
    @(negedge clk);
    chk("abort_D", D, 32'h0);
    chk("abort_flags", {28'd0, busy, done, Bout, V}, 32'd0);
    chk("abort_Z", {31'd0, Z}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    sb_q.push_back(model(a2, b2, $time));
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    #(P * 20000);
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b1; A = 32'h0; B = 32'h0;
    set_hold_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_D", D, 32'h0);
    chk("rst_flags", {28'd0, busy, done, Bout, V}, 32'd0);
    chk("rst_Z", {31'd0, Z}, 32'd1);
    rst = 1'b0; start = 1'b0;
    mon_en = 1'b1;

    run_op(32'h8ED56AC8, 32'h7DA662A9);
    run_op(32'h2EEAAAC8, 32'h56A67559);
    run_op(32'h00000000, 32'h00000001);
    run_op(32'h80000000, 32'h00000001);
    run_op(32'h12345678, 32'h12345678);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(32'h00000010, 32'h00000001);
    for (int i = 0; i < 25; i++) run_op($urandom, $urandom);
    back_to_back(3);
    reset_abort();
    run_op($urandom, $urandom);
    repeat (3 * NBLK) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_serial_subtractor.md
BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; SHALL be a multiple of BLK.
REQ-002 SHALL have parameter BLK, default 4: bits processed per cycle.
REQ-003 SHALL have ports clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have ports rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports start, input, 1, request to begin a subtraction.
REQ-006 SHALL have ports A and B, input, WIDTH each: minuend and subtrahend, two's complement.
REQ-007 SHALL have ports busy, output, 1, high while a subtraction is in progress.
REQ-008 SHALL have ports done, output, 1, one-cycle pulse when the result is valid.
REQ-009 SHALL have ports D, output, WIDTH, difference A-B modulo 2^WIDTH.
REQ-010 SHALL have ports Bout, output, 1, unsigned borrow-out, high iff A<B unsigned.
REQ-011 SHALL have ports V, output, 1, signed overflow.
REQ-012 SHALL have ports Z, output, 1, high iff D==0.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, SHALL capture A and B into internal registers, clear the borrow register and the block index, and go to RUN.
REQ-015 In RUN, SHALL compute one BLK-bit slice per cycle, least significant slice first, using the borrow from the previous slice.
REQ-016 The RUN slice computation SHALL be slice = A_s + ~B_s + ~borrow_in, with borrow_out = ~carry_out.
REQ-017 The RUN slice computation SHALL use block propagate (all A_s XOR ~B_s bits = 1) to pass borrow_in straight to borrow_out.
REQ-018 RUN SHALL last exactly WIDTH/BLK cycles (8 at default); after the last slice, the FSM SHALL go to DONE.
REQ-019 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency from the start-sampling edge to the done=1 cycle SHALL be WIDTH/BLK+1 cycles (9 at default).
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 D, Bout, V and Z SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-023 Bout SHALL equal the final slice borrow.
REQ-024 V SHALL equal (A[MSB]!=B[MSB]) && (D[MSB]!=A[MSB]), using captured operands.
REQ-025 start SHALL be ignored while busy=1; operand changes after capture SHALL not affect the result.
REQ-026 start=1 in the same cycle done=1 SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-027 start held high continuously SHALL produce back-to-back operations every WIDTH/BLK+2 cycles.

Reset
REQ-028 rst=1 SHALL force IDLE, busy=0, done=0, D=0, Bout=0, V=0, Z=1, and clear the index and borrow registers on the next edge.
REQ-029 rst SHALL take priority over start.
REQ-030 rst asserted mid-RUN SHALL abort the operation with no done pulse and no output update.
REQ-031 After rst deasserts, start SHALL be accepted on the first IDLE cycle.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH/BLK constants.
REQ-033 The design SHALL use one sub-module, sub_skip_block: a combinational BLK-bit slice subtractor with borrow-skip.
REQ-034 sub_skip_block SHALL have ports a, b, bin -> d, bout.
REQ-035 sub_skip_block SHALL be instantiated once and time-multiplexed by the FSM.
REQ-036 The block index counter SHALL be log2(WIDTH/BLK) bits wide, and WIDTH/BLK SHALL wrap it to 0 at the end of RUN.

Verification
REQ-037 A=0x8ED56AC8, B=0x7DA662A9, start -> done 9 cycles later; D=0x112F081F, Bout=0, V=1, Z=0.
REQ-038 A=0x2EEAAAC8, B=0x56A67559 -> D=0xD844356F, Bout=1, V=0, Z=0.
REQ-039 A=0x00000000, B=0x00000001 -> D=0xFFFFFFFF, Bout=1, V=0.
REQ-040 A=0x80000000, B=0x00000001 -> D=0x7FFFFFFF, Bout=0, V=1.
REQ-041 A=B=0x12345678 -> D=0, Z=1, Bout=0; also checks that full-block propagate skips the borrow correctly.
REQ-042 start, then rst at RUN cycle 4 -> no done, outputs at reset values; a second start while busy is ignored; the next start gives the correct result.
